// File: rtl/wb_pkg.sv
// Shared types and default sizes for the cache-side write buffer / memory interface.
package wb_pkg;

    localparam int WB_ADDR_W = 16;
    localparam int WB_DATA_W = 32;
    localparam int WB_DEPTH  = 4;

    typedef enum logic [1:0] {
        C_IDLE   = 2'd0,
        C_RDWAIT = 2'd1,
        C_RESP   = 2'd2,
        C_FLUSH  = 2'd3
    } c_state_t;

    typedef enum logic [1:0] {
        M_IDLE  = 2'd0,
        M_WRITE = 2'd1,
        M_READ  = 2'd2
    } m_state_t;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Write buffer storage: in-order FIFO of {addr, data} with a youngest-match
// forwarding lookup across all valid entries.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int ADDR_W = WB_ADDR_W,
    parameter int DATA_W = WB_DATA_W,
    parameter int DEPTH  = WB_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [ADDR_W-1:0] i_push_addr,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_pop,
    input  logic [ADDR_W-1:0] i_lookup_addr,
    output logic [ADDR_W-1:0] o_head_addr,
    output logic [DATA_W-1:0] o_head_data,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_hit,
    output logic [DATA_W-1:0] o_hit_data
);

    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_push;
    logic              w_pop;
    logic              w_hit;
    logic [DATA_W-1:0] w_hit_data;

    assign w_push      = i_push && !o_full;
    assign w_pop       = i_pop && !o_empty;
    assign o_full      = (r_count == CNT_W'(DEPTH));
    assign o_empty     = (r_count == {CNT_W{1'b0}});
    assign o_count     = r_count;
    assign o_head_addr = r_addr[r_rd_ptr];
    assign o_head_data = r_data[r_rd_ptr];
    assign o_hit       = w_hit;
    assign o_hit_data  = w_hit_data;

    // Storage, wrap-around pointers and occupancy count
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i] <= {ADDR_W{1'b0}};
                r_data[i] <= {DATA_W{1'b0}};
            end
        end else begin
            if (w_push) begin
                r_addr[r_wr_ptr] <= i_push_addr;
                r_data[r_wr_ptr] <= i_push_data;
                r_wr_ptr         <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Walk oldest to youngest so a later (younger) match overrides an older one
    always_comb begin
        w_hit      = 1'b0;
        w_hit_data = {DATA_W{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            logic [PTR_W-1:0] v_idx;
            logic             v_match;
            v_idx      = r_rd_ptr + PTR_W'(i);
            v_match    = (CNT_W'(i) < r_count) && (r_addr[v_idx] == i_lookup_addr);
            w_hit      = w_hit | v_match;
            w_hit_data = v_match ? r_data[v_idx] : w_hit_data;
        end
    end

endmodule

// File: rtl/write_buffer_mem_if.sv
// Write-through buffer between the L1 cache controller and main memory:
// cache-side FSM, memory-side FSM and read/drain arbitration.
module write_buffer_mem_if
    import wb_pkg::*;
#(
    parameter int ADDR_W = WB_ADDR_W,
    parameter int DATA_W = WB_DATA_W,
    parameter int DEPTH  = WB_DEPTH,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c_rd,
    input  logic              c_wr,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic [DATA_W-1:0] c_rdata,
    output logic              c_ready,
    input  logic              flush,
    output logic              flush_done,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ack,
    output logic [CNT_W-1:0]  buf_count,
    output logic              buf_full,
    output logic              buf_empty
);

    c_state_t          r_c_state;
    m_state_t          r_m_state;
    logic [DATA_W-1:0] r_c_rdata;
    logic              r_c_ready;
    logic              r_flush_done;
    logic              r_flush_pend;
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_m_req;
    logic              r_m_we;
    logic [ADDR_W-1:0] r_m_addr;
    logic [DATA_W-1:0] r_m_wdata;

    logic              w_push;
    logic              w_pop;
    logic              w_take_flush;
    logic              w_drained;
    logic              w_hit;
    logic [DATA_W-1:0] w_hit_data;
    logic [ADDR_W-1:0] w_head_addr;
    logic [DATA_W-1:0] w_head_data;
    logic [CNT_W-1:0]  w_count;
    logic              w_full;
    logic              w_empty;

    wb_fifo #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk           (clk),
        .rst           (rst),
        .i_push        (w_push),
        .i_push_addr   (c_addr),
        .i_push_data   (c_wdata),
        .i_pop         (w_pop),
        .i_lookup_addr (c_addr),
        .o_head_addr   (w_head_addr),
        .o_head_data   (w_head_data),
        .o_count       (w_count),
        .o_full        (w_full),
        .o_empty       (w_empty),
        .o_hit         (w_hit),
        .o_hit_data    (w_hit_data)
    );

    assign w_take_flush = (r_c_state == C_IDLE) && (flush || r_flush_pend);
    assign w_push       = (r_c_state == C_IDLE) && !w_take_flush && c_wr && !w_full;
    assign w_pop        = (r_m_state == M_WRITE) && m_ack;
    // True when, after this edge, the buffer is empty and memory is idle; lets
    // flush_done follow the final ack by one cycle instead of two.
    assign w_drained    = ((r_m_state == M_IDLE) && w_empty) ||
                          ((r_m_state == M_WRITE) && m_ack && (w_count == CNT_W'(1)));

    assign c_rdata    = r_c_rdata;
    assign c_ready    = r_c_ready;
    assign flush_done = r_flush_done;
    assign m_req      = r_m_req;
    assign m_we       = r_m_we;
    assign m_addr     = r_m_addr;
    assign m_wdata    = r_m_wdata;
    assign buf_count  = w_count;
    assign buf_full   = w_full;
    assign buf_empty  = w_empty;

    // Cache-side FSM: accepts writes, forwards hits, waits on misses, runs flush
    always_ff @(posedge clk) begin
        if (rst) begin
            r_c_state    <= C_IDLE;
            r_c_rdata    <= {DATA_W{1'b0}};
            r_c_ready    <= 1'b0;
            r_flush_done <= 1'b0;
            r_flush_pend <= 1'b0;
            r_rd_addr    <= {ADDR_W{1'b0}};
        end else begin
            r_c_ready    <= 1'b0;
            r_flush_done <= 1'b0;
            case (r_c_state)
                C_IDLE: begin
                    if (w_take_flush) begin
                        r_flush_pend <= 1'b0;
                        if (w_drained) begin
                            r_flush_done <= 1'b1;
                        end else begin
                            r_c_state <= C_FLUSH;
                        end
                    end else if (c_wr) begin
                        if (!w_full) begin
                            r_c_ready <= 1'b1;
                            r_c_state <= C_RESP;
                        end
                    end else if (c_rd) begin
                        if (w_hit) begin
                            r_c_rdata <= w_hit_data;
                            r_c_ready <= 1'b1;
                            r_c_state <= C_RESP;
                        end else begin
                            r_rd_addr <= c_addr;
                            r_c_state <= C_RDWAIT;
                        end
                    end
                end
                C_RDWAIT: begin
                    r_flush_pend <= r_flush_pend | flush;
                    if ((r_m_state == M_READ) && m_ack) begin
                        r_c_rdata <= m_rdata;
                        r_c_ready <= 1'b1;
                        r_c_state <= C_RESP;
                    end
                end
                C_RESP: begin
                    r_flush_pend <= r_flush_pend | flush;
                    r_c_state    <= C_IDLE;
                end
                C_FLUSH: begin
                    if (w_drained) begin
                        r_flush_done <= 1'b1;
                        r_c_state    <= C_IDLE;
                    end
                end
                default: r_c_state <= C_IDLE;
            endcase
        end
    end

    // Memory-side FSM: a pending miss jumps ahead of draining, never preempts a write
    always_ff @(posedge clk) begin
        if (rst) begin
            r_m_state <= M_IDLE;
            r_m_req   <= 1'b0;
            r_m_we    <= 1'b0;
            r_m_addr  <= {ADDR_W{1'b0}};
            r_m_wdata <= {DATA_W{1'b0}};
        end else begin
            case (r_m_state)
                M_IDLE: begin
                    if (r_c_state == C_RDWAIT) begin
                        r_m_req   <= 1'b1;
                        r_m_we    <= 1'b0;
                        r_m_addr  <= r_rd_addr;
                        r_m_state <= M_READ;
                    end else if (!w_empty) begin
                        r_m_req   <= 1'b1;
                        r_m_we    <= 1'b1;
                        r_m_addr  <= w_head_addr;
                        r_m_wdata <= w_head_data;
                        r_m_state <= M_WRITE;
                    end
                end
                M_WRITE, M_READ: begin
                    if (m_ack) begin
                        r_m_req   <= 1'b0;
                        r_m_we    <= 1'b0;
                        r_m_state <= M_IDLE;
                    end
                end
                default: begin
                    r_m_req   <= 1'b0;
                    r_m_state <= M_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_write_buffer_mem_if.sv
// Directed self-checking bench for write_buffer_mem_if; memory acks are driven by hand.
module tb_write_buffer_mem_if;
    import wb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        c_rd, c_wr, flush, m_ack;
    logic [15:0] c_addr;
    logic [31:0] c_wdata, m_rdata;
    logic [31:0] c_rdata, m_wdata;
    logic        c_ready, flush_done, m_req, m_we, buf_full, buf_empty;
    logic [15:0] m_addr;
    logic [2:0]  buf_count;

    int n_checks = 0;
    int n_pass   = 0;
    int rd_req_cnt = 0;
    int rdy_cnt    = 0;
    int illegal_cnt = 0;
    logic [15:0] log_addr [$];
    logic [31:0] log_data [$];
    logic        log_we   [$];

    write_buffer_mem_if dut (
        .clk        (clk),
        .rst        (rst),
        .c_rd       (c_rd),
        .c_wr       (c_wr),
        .c_addr     (c_addr),
        .c_wdata    (c_wdata),
        .c_rdata    (c_rdata),
        .c_ready    (c_ready),
        .flush      (flush),
        .flush_done (flush_done),
        .m_req      (m_req),
        .m_we       (m_we),
        .m_addr     (m_addr),
        .m_wdata    (m_wdata),
        .m_rdata    (m_rdata),
        .m_ack      (m_ack),
        .buf_count  (buf_count),
        .buf_full   (buf_full),
        .buf_empty  (buf_empty)
    );

    always #5 clk = ~clk;

    // Observe completed memory transactions and cache-side activity mid-cycle
    always @(negedge clk) begin
        if (m_req && m_ack) begin
            log_we.push_back(m_we);
            log_addr.push_back(m_addr);
            log_data.push_back(m_wdata);
        end
        if (m_req && !m_we) rd_req_cnt++;
        if (c_ready) rdy_cnt++;
        if (c_rd && c_wr) illegal_cnt++;
    end

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold a cache request until c_ready (bounded), then drop it through the response cycle
    task automatic cache_req(input logic rd, input logic wr, input logic [15:0] a,
                             input logic [31:0] d, output int lat);
        c_rd = rd; c_wr = wr; c_addr = a; c_wdata = d; lat = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (c_ready) begin
                lat = i;
                break;
            end
        end
        c_rd = 1'b0; c_wr = 1'b0;
        step();
    endtask

    // Wait (bounded) for m_req, then return a one-cycle ack
    task automatic drain_one(input logic [31:0] rdat, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (m_req) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (ok) begin
            m_ack = 1'b1; m_rdata = rdat;
            step();
            m_ack = 1'b0;
        end
    endtask

    initial begin
        int        lat;
        int        base;
        int        snap;
        logic      ok;
        logic      seen;
        wb_entry_t vec [5];

        vec[0] = '{addr: 16'h0010, data: 32'h0000_0100};
        vec[1] = '{addr: 16'h0011, data: 32'h0000_0101};
        vec[2] = '{addr: 16'h0012, data: 32'h0000_0102};
        vec[3] = '{addr: 16'h0013, data: 32'h0000_0103};
        vec[4] = '{addr: 16'h0020, data: 32'h0000_0200};

        rst = 1'b1; c_rd = 1'b0; c_wr = 1'b0; flush = 1'b0; m_ack = 1'b0;
        c_addr = 16'h0000; c_wdata = 32'h0; m_rdata = 32'h0;
        step(); step();
        chk_eq("rst_c_ready", c_ready, 1'b0);
        chk_eq("rst_m_req", m_req, 1'b0);
        chk_eq("rst_flush_done", flush_done, 1'b0);
        chk_eq("rst_c_rdata", c_rdata, 32'h0);
        chk_eq("rst_buf_count", buf_count, 3'd0);
        chk_eq("rst_buf_empty", buf_empty, 1'b1);
        rst = 1'b0;

        // 1: single write, drained with a delayed ack
        c_wr = 1'b1; c_addr = 16'h00AA; c_wdata = 32'd11;
        step();
        chk_eq("t1_c_ready", c_ready, 1'b1);
        chk_eq("t1_count", buf_count, 3'd1);
        chk_eq("t1_no_req_yet", m_req, 1'b0);
        c_wr = 1'b0;
        step();
        chk_eq("t1_m_req", m_req, 1'b1);
        chk_eq("t1_m_we", m_we, 1'b1);
        chk_eq("t1_m_addr", m_addr, 16'h00AA);
        chk_eq("t1_m_wdata", m_wdata, 32'd11);
        step(); step();
        chk_eq("t1_req_held", m_req, 1'b1);
        m_ack = 1'b1;
        step();
        m_ack = 1'b0;
        chk_eq("t1_empty", buf_empty, 1'b1);
        chk_eq("t1_req_drop", m_req, 1'b0);

        // 2: read hit forwarded from the buffer
        snap = rd_req_cnt;
        cache_req(1'b0, 1'b1, 16'h00AB, 32'd22, lat);
        chk_eq("t2_wr_lat", lat, 1);
        cache_req(1'b1, 1'b0, 16'h00AB, 32'd0, lat);
        chk_eq("t2_rd_lat", lat, 1);
        chk_eq("t2_rdata", c_rdata, 32'd22);
        chk_eq("t2_no_mem_read", rd_req_cnt - snap, 0);
        drain_one(32'h0, ok);
        chk_eq("t2_drain", ok, 1'b1);

        // 3: fill to DEPTH, fifth write stalls until one slot frees
        for (int i = 0; i < 4; i++) begin
            cache_req(1'b0, 1'b1, vec[i].addr, vec[i].data, lat);
            chk_eq("t3_fill_lat", lat, 1);
        end
        chk_eq("t3_full", buf_full, 1'b1);
        chk_eq("t3_count4", buf_count, 3'd4);
        base = log_addr.size();
        c_wr = 1'b1; c_addr = vec[4].addr; c_wdata = vec[4].data;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            seen = seen | c_ready;
        end
        m_ack = 1'b1;
        step();
        m_ack = 1'b0;
        seen = seen | c_ready;
        chk_eq("t3_stalled", seen, 1'b0);
        step();
        chk_eq("t3_accept", c_ready, 1'b1);
        chk_eq("t3_count_back", buf_count, 3'd4);
        c_wr = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            drain_one(32'h0, ok);
            chk_eq("t3_drain", ok, 1'b1);
        end
        for (int i = 0; i < 5; i++) begin
            chk_eq("t3_order_addr", log_addr[base+i], vec[i].addr);
            chk_eq("t3_order_data", log_data[base+i], vec[i].data);
        end

        // 4: read miss overtakes remaining entries after the in-flight write
        cache_req(1'b0, 1'b1, 16'h00AA, 32'd1, lat);
        cache_req(1'b0, 1'b1, 16'h00AB, 32'd2, lat);
        c_rd = 1'b1; c_addr = 16'h00AC;
        step();
        chk_eq("t4_inflight_we", m_we, 1'b1);
        chk_eq("t4_inflight_addr", m_addr, 16'h00AA);
        m_ack = 1'b1;
        step();
        m_ack = 1'b0;
        step();
        chk_eq("t4_rd_req", m_req, 1'b1);
        chk_eq("t4_rd_we", m_we, 1'b0);
        chk_eq("t4_rd_addr", m_addr, 16'h00AC);
        chk_eq("t4_ab_waiting", buf_count, 3'd1);
        m_ack = 1'b1; m_rdata = 32'd3;
        step();
        m_ack = 1'b0;
        chk_eq("t4_c_ready", c_ready, 1'b1);
        chk_eq("t4_rdata", c_rdata, 32'd3);
        c_rd = 1'b0;
        step();
        chk_eq("t4_ab_we", m_we, 1'b1);
        chk_eq("t4_ab_addr", m_addr, 16'h00AB);
        chk_eq("t4_ab_data", m_wdata, 32'd2);
        m_ack = 1'b1;
        step();
        m_ack = 1'b0;
        chk_eq("t4_empty", buf_empty, 1'b1);

        // 5: duplicate addresses, youngest wins, both drained in order
        cache_req(1'b0, 1'b1, 16'h00AA, 32'd1, lat);
        cache_req(1'b0, 1'b1, 16'h00AA, 32'd5, lat);
        cache_req(1'b1, 1'b0, 16'h00AA, 32'd0, lat);
        chk_eq("t5_rd_lat", lat, 1);
        chk_eq("t5_youngest", c_rdata, 32'd5);
        base = log_data.size();
        drain_one(32'h0, ok);
        drain_one(32'h0, ok);
        chk_eq("t5_first", log_data[base], 32'd1);
        chk_eq("t5_second", log_data[base+1], 32'd5);

        // 6a: flush with three entries, read stalled until after flush_done
        for (int i = 0; i < 3; i++) begin
            cache_req(1'b0, 1'b1, 16'h0030 + 16'(i), 32'd7 + 32'(i), lat);
        end
        snap = rdy_cnt;
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk_eq("t6_no_early_done", flush_done, 1'b0);
        c_rd = 1'b1; c_addr = 16'h0099;
        for (int i = 0; i < 3; i++) begin
            drain_one(32'h0, ok);
            chk_eq("t6_drain", ok, 1'b1);
        end
        chk_eq("t6_flush_done", flush_done, 1'b1);
        chk_eq("t6_rd_stalled", rdy_cnt - snap, 0);
        step();
        chk_eq("t6_done_pulse", flush_done, 1'b0);
        chk_eq("t6_no_ready", c_ready, 1'b0);
        drain_one(32'h55, ok);
        chk_eq("t6_rd_issued", ok, 1'b1);
        chk_eq("t6_rd_ready", c_ready, 1'b1);
        chk_eq("t6_rd_data", c_rdata, 32'h55);
        c_rd = 1'b0;
        step();

        // flush with an empty buffer completes the next cycle
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk_eq("t6_empty_flush", flush_done, 1'b1);
        step();
        chk_eq("t6_empty_pulse", flush_done, 1'b0);

        // 6b: reset while a write is in flight
        cache_req(1'b0, 1'b1, 16'h0040, 32'hE, lat);
        chk_eq("t6_wr_inflight", m_req, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_eq("t6_rst_m_req", m_req, 1'b0);
        chk_eq("t6_rst_empty", buf_empty, 1'b1);
        chk_eq("t6_rst_c_ready", c_ready, 1'b0);
        chk_eq("t6_rst_count", buf_count, 3'd0);

        chk_eq("no_rd_wr_overlap", illegal_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
